// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine.
// The control unit imports the op encodings from here as well.
package hilo_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the control unit (master) and the HI/LO engine (slave).
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, sgn, a, b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, sgn, a, b, hi_wr, lo_wr, wr_data,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/hilo_sign_mag.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// Gives operand magnitudes on the way in and restores result signs on the way out.
module hilo_sign_mag #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider owning the HI/LO pair.
// Optional build macro HILO_EARLY_TERM_EN: MUL leaves RUN once the remaining multiplier bits are zero.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              clear,
  hilo_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;

  state_e             state_r, state_nx_s;
  logic [CNT_W-1:0]   count_r, count_nx_s;
  op_e                op_r, op_nx_s;
  logic               dbz_r, dbz_nx_s;
  logic               neg_res_r, neg_res_nx_s;
  logic               neg_rem_r, neg_rem_nx_s;
  logic [W2-1:0]      acc_r, acc_nx_s;
  logic [W2-1:0]      mcand_r, mcand_nx_s;
  logic [WIDTH-1:0]   mplier_r, mplier_nx_s;
  logic [WIDTH-1:0]   hi_r, hi_nx_s;
  logic [WIDTH-1:0]   lo_r, lo_nx_s;
  logic               busy_r, done_r, dz_r;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [W2-1:0]      prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;
  logic [WIDTH:0]     trial_s;
  logic [W2-1:0]      div_step_s;
  logic               run_last_s;

  hilo_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
    .val (bus.a),
    .neg (bus.sgn & bus.a[WIDTH-1]),
    .res (a_mag_s)
  );

  hilo_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
    .val (bus.b),
    .neg (bus.sgn & bus.b[WIDTH-1]),
    .res (b_mag_s)
  );

  hilo_sign_mag #(.WIDTH(W2)) u_fix_prod (
    .val (acc_r),
    .neg (neg_res_r),
    .res (prod_fix_s)
  );

  hilo_sign_mag #(.WIDTH(WIDTH)) u_fix_quot (
    .val (acc_r[WIDTH-1:0]),
    .neg (neg_res_r),
    .res (quot_fix_s)
  );

  hilo_sign_mag #(.WIDTH(WIDTH)) u_fix_rem (
    .val (acc_r[W2-1:WIDTH]),
    .neg (neg_rem_r),
    .res (rem_fix_s)
  );

  // Restoring divide step: acc holds {partial remainder, unshifted dividend/quotient bits}
  always_comb begin
    trial_s    = {acc_r[W2-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, mcand_r[WIDTH-1:0]};
    div_step_s = {acc_r[W2-2:0], 1'b0};
    if (!trial_s[WIDTH]) begin
      div_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_step_s = {acc_r[W2-2:0], 1'b0};
    end
  end

  // Decide whether this RUN edge is the last iteration
  always_comb begin
`ifdef HILO_EARLY_TERM_EN
    if (op_r == OP_MUL) begin
      run_last_s = (mplier_r[WIDTH-1:1] == '0);
    end else begin
      run_last_s = (count_r == CNT_W'(1));
    end
`else
    run_last_s = (count_r == CNT_W'(1));
`endif
  end

  // Next-state and datapath update for IDLE -> RUN -> FIX -> IDLE
  always_comb begin
    state_nx_s   = state_r;
    count_nx_s   = count_r;
    op_nx_s      = op_r;
    dbz_nx_s     = dbz_r;
    neg_res_nx_s = neg_res_r;
    neg_rem_nx_s = neg_rem_r;
    acc_nx_s     = acc_r;
    mcand_nx_s   = mcand_r;
    mplier_nx_s  = mplier_r;
    hi_nx_s      = hi_r;
    lo_nx_s      = lo_r;

    if (bus.hi_wr) begin
      hi_nx_s = bus.wr_data;
    end else begin
      hi_nx_s = hi_r;
    end
    if (bus.lo_wr) begin
      lo_nx_s = bus.wr_data;
    end else begin
      lo_nx_s = lo_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          op_nx_s      = op_e'(bus.op);
          neg_res_nx_s = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_nx_s = bus.sgn & bus.a[WIDTH-1];
          count_nx_s   = CNT_W'(WIDTH);
          mplier_nx_s  = '0;
          if ((op_e'(bus.op) == OP_DIV) && (bus.b == '0)) begin
            // Raw dividend goes to HI untouched; the sign fix-up is bypassed
            dbz_nx_s   = 1'b1;
            acc_nx_s   = {bus.a, {WIDTH{1'b1}}};
            mcand_nx_s = '0;
            state_nx_s = ST_FIX;
          end else if (op_e'(bus.op) == OP_DIV) begin
            dbz_nx_s   = 1'b0;
            acc_nx_s   = {{WIDTH{1'b0}}, a_mag_s};
            mcand_nx_s = {{WIDTH{1'b0}}, b_mag_s};
            state_nx_s = ST_RUN;
          end else begin
            dbz_nx_s    = 1'b0;
            acc_nx_s    = '0;
            mcand_nx_s  = {{WIDTH{1'b0}}, a_mag_s};
            mplier_nx_s = b_mag_s;
            state_nx_s  = ST_RUN;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        count_nx_s = count_r - CNT_W'(1);
        if (op_r == OP_MUL) begin
          // Multiplicand shifts left so the product is always in final alignment
          if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
          end else begin
            acc_nx_s = acc_r;
          end
          mcand_nx_s  = mcand_r << 1;
          mplier_nx_s = mplier_r >> 1;
        end else begin
          acc_nx_s = div_step_s;
        end
        if (run_last_s) begin
          state_nx_s = ST_FIX;
        end else begin
          state_nx_s = ST_RUN;
        end
      end

      ST_FIX: begin
        state_nx_s = ST_IDLE;
        count_nx_s = '0;
        if (dbz_r) begin
          hi_nx_s = acc_r[W2-1:WIDTH];
          lo_nx_s = acc_r[WIDTH-1:0];
        end else if (op_r == OP_MUL) begin
          hi_nx_s = prod_fix_s[W2-1:WIDTH];
          lo_nx_s = prod_fix_s[WIDTH-1:0];
        end else begin
          hi_nx_s = rem_fix_s;
          lo_nx_s = quot_fix_s;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      op_r      <= OP_MUL;
      dbz_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      count_r   <= count_nx_s;
      op_r      <= op_nx_s;
      dbz_r     <= dbz_nx_s;
      neg_res_r <= neg_res_nx_s;
      neg_rem_r <= neg_rem_nx_s;
      acc_r     <= acc_nx_s;
      mcand_r   <= mcand_nx_s;
      mplier_r  <= mplier_nx_s;
      hi_r      <= hi_nx_s;
      lo_r      <= lo_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
      done_r    <= (state_r == ST_FIX);
      dz_r      <= (state_r == ST_FIX) && dbz_r;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (WIDTH=32).
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int W = 32;

  logic clk;
  logic clear;
  int   checks;
  int   errors;
  int   lat;
  int   bcyc;
  int   done_seen;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start edge k happens inside; returns n such that done is visible after edge k+n
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (1) begin
      tick();
      n++;
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_cycles++;
      if (n > 100) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=%0d expected=done", n);
        break;
      end
    end
  endtask

  task automatic run_op(input logic op, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int n, output int busy_cycles);
    bus.op    = op;
    bus.sgn   = sgn;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n, busy_cycles);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.start    = 1'b0;
    bus.op       = 1'b0;
    bus.sgn      = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.hi_wr    = 1'b0;
    bus.lo_wr    = 1'b0;
    bus.wr_data  = '0;
    clear        = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz",   64'(bus.div_by_zero), 64'd0);
    chk("rst_hi",   64'(bus.hi), 64'd0);
    chk("rst_lo",   64'(bus.lo), 64'd0);

    // 1. unsigned max*max, fixed latency
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
    chk("mul_u_lat",  64'(lat), 64'd33);
    chk("mul_u_busy", 64'(bcyc), 64'd33);
    chk("mul_u_busy_at_done", 64'(bus.busy), 64'd0);
    chk("mul_u_hi", 64'(bus.hi), 64'hFFFFFFFE);
    chk("mul_u_lo", 64'(bus.lo), 64'h00000001);
    chk("mul_u_dz", 64'(bus.div_by_zero), 64'd0);
    tick();
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    // 2. signed -3*7
    run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, lat, bcyc);
    chk("mul_s_hi", 64'(bus.hi), 64'hFFFFFFFF);
    chk("mul_s_lo", 64'(bus.lo), 64'hFFFFFFEB);

    // multiplier of 1: latency depends on the early-termination build
    run_op(1'b0, 1'b0, 32'd5, 32'd1, lat, bcyc);
`ifdef HILO_EARLY_TERM_EN
    chk("mul_b1_lat", 64'(lat), 64'd2);
`else
    chk("mul_b1_lat", 64'(lat), 64'd33);
`endif
    chk("mul_b1_hi", 64'(bus.hi), 64'd0);
    chk("mul_b1_lo", 64'(bus.lo), 64'd5);

    // 3. divides
    run_op(1'b1, 1'b1, 32'hFFFFFFEF, 32'd5, lat, bcyc);
    chk("div_s_lat", 64'(lat), 64'd33);
    chk("div_s_lo", 64'(bus.lo), 64'hFFFFFFFD);
    chk("div_s_hi", 64'(bus.hi), 64'hFFFFFFFE);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, bcyc);
    chk("div_u_lo", 64'(bus.lo), 64'd14);
    chk("div_u_hi", 64'(bus.hi), 64'd2);
    run_op(1'b1, 1'b1, 32'd17, 32'hFFFFFFFB, lat, bcyc);
    chk("div_s2_lo", 64'(bus.lo), 64'hFFFFFFFD);
    chk("div_s2_hi", 64'(bus.hi), 64'd2);

    // 4. divide by zero
    run_op(1'b1, 1'b0, 32'h00001234, 32'd0, lat, bcyc);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    chk("dbz_hi", 64'(bus.hi), 64'h00001234);
    chk("dbz_lo", 64'(bus.lo), 64'hFFFFFFFF);
    tick();
    chk("dbz_one_cycle", 64'(bus.div_by_zero), 64'd0);

    // 5. MIN / -1, then back-to-back start on the done cycle
    run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
    chk("div_min_lo", 64'(bus.lo), 64'h80000000);
    chk("div_min_hi", 64'(bus.hi), 64'd0);
    run_op(1'b0, 1'b0, 32'd6, 32'd7, lat, bcyc);
    chk("b2b_busy", 64'(bcyc > 0), 64'd1);
    chk("b2b_lo", 64'(bus.lo), 64'd42);
    chk("b2b_hi", 64'(bus.hi), 64'd0);

    // 6. direct writes in IDLE
    bus.lo_wr   = 1'b1;
    bus.wr_data = 32'hFFFF0000;
    tick();
    bus.lo_wr   = 1'b0;
    chk("mtlo", 64'(bus.lo), 64'hFFFF0000);
    bus.hi_wr   = 1'b1;
    bus.wr_data = 32'h0000ABCD;
    tick();
    bus.hi_wr   = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h0000ABCD);

    // clear mid-run at count=10 (22 edges after start)
    bus.op = 1'b0; bus.sgn = 1'b0; bus.a = 32'd9; bus.b = 32'hFFFFFFFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 22; i++) tick();
    chk("pre_clear_busy", 64'(bus.busy), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_hi", 64'(bus.hi), 64'd0);
    chk("clr_lo", 64'(bus.lo), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    chk("clr_no_done", 64'(done_seen), 64'd0);

    // start while busy is ignored
    bus.op = 1'b0; bus.sgn = 1'b0; bus.a = 32'd3; bus.b = 32'hFFFFFFFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      lat++;
    end
    bus.op = 1'b1; bus.a = 32'd100; bus.b = 32'd0;
    bus.start = 1'b1;
    tick();
    lat++;
    bus.start = 1'b0;
    wait_done(bcyc, done_seen);
    chk("ign_lat", 64'(lat + bcyc - 1), 64'd33);
    chk("ign_dz", 64'(bus.div_by_zero), 64'd0);
    chk("ign_hi", 64'(bus.hi), 64'h00000002);
    chk("ign_lo", 64'(bus.lo), 64'hFFFFFFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
